// File: rtl/uart_cmd_decoder_if.sv
// Bundles the byte stream from the UART receiver and the decoder's
// register-file and status outputs.
interface uart_cmd_decoder_if;
  logic        i_Rx_DV;
  logic [7:0]  i_Rx_Byte;
  logic [31:0] o_Reg_Flat;
  logic        o_Wr_Strobe;
  logic [1:0]  o_Wr_Addr;
  logic        o_Err;
  logic [7:0]  o_Err_Count;

  modport master (
    output i_Rx_DV, i_Rx_Byte,
    input  o_Reg_Flat, o_Wr_Strobe, o_Wr_Addr, o_Err, o_Err_Count
  );

  modport slave (
    input  i_Rx_DV, i_Rx_Byte,
    output o_Reg_Flat, o_Wr_Strobe, o_Wr_Addr, o_Err, o_Err_Count
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Parses SYNC/ADDR/DATA/CHK frames from a UART byte stream into a 4x8 register
// file, flagging bad frames and inter-byte timeouts on o_Err.
module uart_cmd_decoder #(
  parameter int         TIMEOUT_CLKS = 2000,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  uart_cmd_decoder_if.slave  bus
);

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_CHK  = 2'd3
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CLKS - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_timer;
  logic [15:0] w_timer_next;
  logic [7:0]  r_addr;
  logic [7:0]  r_data;
  logic [31:0] r_regs;
  logic        r_wr_strobe;
  logic [1:0]  r_wr_addr;
  logic        r_err;
  logic [7:0]  r_err_count;

  logic        w_latch_addr;
  logic        w_latch_data;
  logic        w_commit;
  logic        w_reject;
  logic        w_expired;
  logic [7:0]  w_sum;
  logic        w_frame_ok;

  assign w_sum      = r_addr + r_data;
  assign w_frame_ok = (bus.i_Rx_Byte == w_sum) && (r_addr[7:2] == 6'd0);

  // A byte arriving in the expiry cycle wins over the timeout
  assign w_expired  = (r_state != S_SYNC) && !bus.i_Rx_DV && (r_timer == TIMEOUT_LAST);

  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer + 16'd1;
    w_latch_addr = 1'b0;
    w_latch_data = 1'b0;
    w_commit     = 1'b0;
    w_reject     = 1'b0;

    case (r_state)
      S_SYNC: begin
        if (bus.i_Rx_DV && (bus.i_Rx_Byte == SYNC_BYTE)) begin
          w_state_next = S_ADDR;
        end else begin
          w_state_next = S_SYNC;
        end
      end
      S_ADDR: begin
        if (bus.i_Rx_DV) begin
          w_latch_addr = 1'b1;
          w_state_next = S_DATA;
        end else begin
          w_state_next = S_ADDR;
        end
      end
      S_DATA: begin
        if (bus.i_Rx_DV) begin
          w_latch_data = 1'b1;
          w_state_next = S_CHK;
        end else begin
          w_state_next = S_DATA;
        end
      end
      S_CHK: begin
        if (bus.i_Rx_DV) begin
          w_commit     = w_frame_ok;
          w_reject     = !w_frame_ok;
          w_state_next = S_SYNC;
        end else begin
          w_state_next = S_CHK;
        end
      end
      default: begin
        w_state_next = S_SYNC;
      end
    endcase

    if (w_expired) begin
      w_state_next = S_SYNC;
    end else begin
      w_state_next = w_state_next;
    end

    if (bus.i_Rx_DV || (r_state == S_SYNC) || w_expired) begin
      w_timer_next = 16'd0;
    end else begin
      w_timer_next = r_timer + 16'd1;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state     <= S_SYNC;
      r_timer     <= 16'd0;
      r_addr      <= 8'd0;
      r_data      <= 8'd0;
      r_regs      <= 32'd0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= 2'd0;
      r_err       <= 1'b0;
      r_err_count <= 8'd0;
    end else begin
      r_state     <= w_state_next;
      r_timer     <= w_timer_next;
      r_wr_strobe <= w_commit;
      r_err       <= w_reject || w_expired;
      if (w_latch_addr) begin
        r_addr <= bus.i_Rx_Byte;
      end
      if (w_latch_data) begin
        r_data <= bus.i_Rx_Byte;
      end
      if (w_commit) begin
        r_regs[{r_addr[1:0], 3'b000} +: 8] <= r_data;
        r_wr_addr                          <= r_addr[1:0];
      end
      if ((w_reject || w_expired) && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign bus.o_Reg_Flat  = r_regs;
  assign bus.o_Wr_Strobe = r_wr_strobe;
  assign bus.o_Wr_Addr   = r_wr_addr;
  assign bus.o_Err       = r_err;
  assign bus.o_Err_Count = r_err_count;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scenario and randomized checks of uart_cmd_decoder against a frame-level
// reference model that collects bytes in a queue.
module tb_uart_cmd_decoder;
  localparam int         T    = 20;
  localparam logic [7:0] SYNC = 8'hA5;

  logic clk = 1'b0;
  logic rst;
  uart_cmd_decoder_if bus ();

  uart_cmd_decoder #(.TIMEOUT_CLKS(T), .SYNC_BYTE(SYNC)) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: bytes of the frame in progress, idle cycles since the last byte
  logic [7:0] m_q[$];
  int         m_idle;
  logic [7:0] m_regs[4];
  logic [1:0] m_waddr;
  int         m_cnt;
  bit         m_strobe;
  bit         m_err;
  int         n_wr;
  int         n_err;

  function automatic logic [31:0] m_flat();
    return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_idle   = 0;
    for (int i = 0; i < 4; i++) m_regs[i] = 8'd0;
    m_waddr  = 2'd0;
    m_cnt    = 0;
    m_strobe = 1'b0;
    m_err    = 1'b0;
  endtask

  task automatic m_bad();
    m_err = 1'b1;
    if (m_cnt < 255) m_cnt++;
  endtask

  // One clock: drive inputs, advance model, sample just after the edge
  task automatic step(input bit dv, input logic [7:0] b);
    logic [7:0] a, d;
    @(negedge clk);
    bus.i_Rx_DV   = dv;
    bus.i_Rx_Byte = b;
    m_strobe = 1'b0;
    m_err    = 1'b0;
    if (dv) begin
      m_idle = 0;
      if (m_q.size() == 0) begin
        if (b == SYNC) m_q.push_back(b);
      end else begin
        m_q.push_back(b);
        if (m_q.size() == 4) begin
          a = m_q[1];
          d = m_q[2];
          if (a < 8'd4 && b == 8'(a + d)) begin
            m_regs[a[1:0]] = d;
            m_waddr        = a[1:0];
            m_strobe       = 1'b1;
          end else begin
            m_bad();
          end
          m_q.delete();
        end
      end
    end else if (m_q.size() != 0) begin
      m_idle++;
      if (m_idle == T) begin
        m_q.delete();
        m_idle = 0;
        m_bad();
      end
    end
    @(posedge clk);
    #1;
    n_wr  += int'(bus.o_Wr_Strobe);
    n_err += int'(bus.o_Err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0);
  endtask

  task automatic send(input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3);
    step(1'b1, b0);
    step(1'b1, b1);
    step(1'b1, b2);
    step(1'b1, b3);
    step(1'b0, 8'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_Rx_DV   = 1'b0;
    bus.i_Rx_Byte = 8'd0;
    m_reset();
    n_wr  = 0;
    n_err = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.o_Reg_Flat, bus.o_Wr_Strobe, bus.o_Wr_Addr, bus.o_Err, bus.o_Err_Count} !== 44'd0) begin
      errors++;
      $display("FAIL reset_outputs: got flat=%h st=%b wa=%0d err=%b cnt=%0d, need all 0",
               bus.o_Reg_Flat, bus.o_Wr_Strobe, bus.o_Wr_Addr, bus.o_Err, bus.o_Err_Count);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_valid();
    int w0 = n_wr;
    step(1'b1, 8'hA5);
    step(1'b1, 8'h02);
    step(1'b1, 8'h3C);
    step(1'b1, 8'h3E);
    checks++;
    if (bus.o_Wr_Strobe !== 1'b1 || bus.o_Wr_Addr !== 2'd2 || bus.o_Reg_Flat !== 32'h003C_0000) begin
      errors++;
      $display("FAIL valid_commit: got st=%b wa=%0d flat=%h, need st=1 wa=2 flat=003c0000",
               bus.o_Wr_Strobe, bus.o_Wr_Addr, bus.o_Reg_Flat);
    end
    checks++;
    if (bus.o_Err !== 1'b0) begin
      errors++;
      $display("FAIL valid_no_err: got err=%b need 0", bus.o_Err);
    end
    idle(3);
    checks++;
    if (n_wr - w0 != 1 || bus.o_Wr_Addr !== 2'd2) begin
      errors++;
      $display("FAIL valid_one_strobe: got %0d strobes wa=%0d, need 1 wa=2", n_wr - w0, bus.o_Wr_Addr);
    end
  endtask

  task automatic test_bad_chk();
    int w0 = n_wr;
    step(1'b1, 8'hA5);
    step(1'b1, 8'h01);
    step(1'b1, 8'h10);
    step(1'b1, 8'h12);
    checks++;
    if (bus.o_Err !== 1'b1 || bus.o_Err_Count !== 8'd1) begin
      errors++;
      $display("FAIL bad_chk_err: got err=%b cnt=%0d, need err=1 cnt=1", bus.o_Err, bus.o_Err_Count);
    end
    step(1'b0, 8'd0);
    checks++;
    if (bus.o_Err !== 1'b0 || n_wr != w0 || bus.o_Reg_Flat !== 32'h003C_0000) begin
      errors++;
      $display("FAIL bad_chk_nowrite: got err=%b strobes=%0d flat=%h, need 0 0 003c0000",
               bus.o_Err, n_wr - w0, bus.o_Reg_Flat);
    end
  endtask

  task automatic test_bad_addr();
    int w0 = n_wr;
    int e0 = n_err;
    send(8'hA5, 8'h04, 8'h10, 8'h14);
    checks++;
    if (n_err - e0 != 1 || n_wr != w0 || bus.o_Err_Count !== 8'd2 || bus.o_Reg_Flat !== 32'h003C_0000) begin
      errors++;
      $display("FAIL bad_addr: got errs=%0d wr=%0d cnt=%0d flat=%h, need 1 0 2 003c0000",
               n_err - e0, n_wr - w0, bus.o_Err_Count, bus.o_Reg_Flat);
    end
  endtask

  task automatic test_timeout();
    int e0 = n_err;
    step(1'b1, 8'hA5);
    step(1'b1, 8'h03);
    idle(T - 1);
    checks++;
    if (n_err != e0) begin
      errors++;
      $display("FAIL timeout_early: got %0d errs before expiry, need 0", n_err - e0);
    end
    step(1'b0, 8'd0);
    checks++;
    if (bus.o_Err !== 1'b1 || bus.o_Err_Count !== 8'd3) begin
      errors++;
      $display("FAIL timeout_err: got err=%b cnt=%0d, need err=1 cnt=3", bus.o_Err, bus.o_Err_Count);
    end
    step(1'b0, 8'd0);
    checks++;
    if (bus.o_Err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: got err=%b, need 0", bus.o_Err);
    end
    send(8'hA5, 8'h03, 8'hFF, 8'h02);
    checks++;
    if (bus.o_Reg_Flat !== 32'hFF3C_0000 || bus.o_Wr_Addr !== 2'd3) begin
      errors++;
      $display("FAIL timeout_resync: got flat=%h wa=%0d, need ff3c0000 wa=3", bus.o_Reg_Flat, bus.o_Wr_Addr);
    end
  endtask

  task automatic test_junk();
    int e0 = n_err;
    int w0 = n_wr;
    step(1'b1, 8'h00);
    step(1'b1, 8'hA5);
    step(1'b1, 8'hA5);
    step(1'b1, 8'h01);
    step(1'b1, 8'h10);
    checks++;
    if (bus.o_Err !== 1'b1 || bus.o_Err !== m_err) begin
      errors++;
      $display("FAIL junk_reject: got err=%b, need 1", bus.o_Err);
    end
    step(1'b1, 8'hB5);
    idle(T + 5);
    checks++;
    if (n_err - e0 != 1 || n_wr != w0 || bus.o_Err_Count !== 8'd4 || bus.o_Reg_Flat !== 32'hFF3C_0000) begin
      errors++;
      $display("FAIL junk_discard: got errs=%0d wr=%0d cnt=%0d flat=%h, need 1 0 4 ff3c0000",
               n_err - e0, n_wr - w0, bus.o_Err_Count, bus.o_Reg_Flat);
    end
  endtask

  task automatic test_back_to_back();
    int w0 = n_wr;
    step(1'b1, 8'hA5);
    step(1'b1, 8'h01);
    step(1'b1, 8'hA5);
    step(1'b1, 8'hA6);
    step(1'b1, 8'hA5);
    step(1'b1, 8'h00);
    step(1'b1, 8'h77);
    step(1'b1, 8'h77);
    step(1'b0, 8'd0);
    checks++;
    if (n_wr - w0 != 2 || bus.o_Reg_Flat !== 32'hFF3C_A577 || bus.o_Wr_Addr !== 2'd0) begin
      errors++;
      $display("FAIL b2b: got wr=%0d flat=%h wa=%0d, need 2 ff3ca577 0", n_wr - w0, bus.o_Reg_Flat, bus.o_Wr_Addr);
    end
  endtask

  task automatic test_random();
    bit         q_dv[$];
    logic [7:0] q_b[$];
    logic [7:0] fr[4];
    int         gap;
    for (int f = 0; f < 40; f++) begin
      fr[0] = SYNC;
      fr[1] = 8'($urandom_range(0, 5));
      fr[2] = 8'($urandom);
      fr[3] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(fr[1] + fr[2]);
      if ($urandom_range(0, 5) == 0) begin
        q_dv.push_back(1'b1);
        q_b.push_back(8'($urandom));
      end
      for (int k = 0; k < 4; k++) begin
        gap = ($urandom_range(0, 12) == 0) ? T + 1 : int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) begin
          q_dv.push_back(1'b0);
          q_b.push_back(8'($urandom));
        end
        q_dv.push_back(1'b1);
        q_b.push_back(fr[k]);
      end
    end
    for (int i = 0; i < q_dv.size(); i++) begin
      step(q_dv[i], q_b[i]);
      checks++;
      if (bus.o_Wr_Strobe !== m_strobe || bus.o_Err !== m_err) begin
        errors++;
        $display("FAIL rand_pulse[%0d]: got st=%b err=%b, need st=%b err=%b",
                 i, bus.o_Wr_Strobe, bus.o_Err, m_strobe, m_err);
      end
      checks++;
      if (bus.o_Reg_Flat !== m_flat() || bus.o_Wr_Addr !== m_waddr || bus.o_Err_Count !== 8'(m_cnt)) begin
        errors++;
        $display("FAIL rand_state[%0d]: got flat=%h wa=%0d cnt=%0d, need flat=%h wa=%0d cnt=%0d",
                 i, bus.o_Reg_Flat, bus.o_Wr_Addr, bus.o_Err_Count, m_flat(), m_waddr, m_cnt);
      end
    end
    idle(T + 2);
  endtask

  task automatic test_saturate();
    logic [31:0] flat0 = bus.o_Reg_Flat;
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 8'hA5);
      step(1'b1, 8'h00);
      step(1'b1, 8'h00);
      step(1'b1, 8'h01);
    end
    step(1'b0, 8'd0);
    checks++;
    if (bus.o_Err_Count !== 8'd255 || m_cnt != 255) begin
      errors++;
      $display("FAIL saturate: got cnt=%0d, need 255", bus.o_Err_Count);
    end
    checks++;
    if (bus.o_Reg_Flat !== flat0) begin
      errors++;
      $display("FAIL saturate_regs: got flat=%h, need %h", bus.o_Reg_Flat, flat0);
    end
  endtask

  task automatic test_reset_midframe();
    int w0;
    int e0;
    step(1'b1, 8'hA5);
    step(1'b1, 8'h00);
    @(negedge clk);
    bus.i_Rx_DV = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.o_Reg_Flat, bus.o_Wr_Strobe, bus.o_Wr_Addr, bus.o_Err, bus.o_Err_Count} !== 44'd0) begin
      errors++;
      $display("FAIL midframe_async_reset: got flat=%h st=%b wa=%0d err=%b cnt=%0d, need all 0",
               bus.o_Reg_Flat, bus.o_Wr_Strobe, bus.o_Wr_Addr, bus.o_Err, bus.o_Err_Count);
    end
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    w0 = n_wr;
    e0 = n_err;
    idle(T + 3);
    checks++;
    if (n_wr != w0 || n_err != e0 || bus.o_Reg_Flat !== 32'd0) begin
      errors++;
      $display("FAIL midframe_abort: got wr=%0d errs=%0d flat=%h, need 0 0 0", n_wr - w0, n_err - e0, bus.o_Reg_Flat);
    end
    send(8'hA5, 8'h01, 8'h5A, 8'h5B);
    checks++;
    if (bus.o_Reg_Flat !== 32'h0000_5A00 || n_wr - w0 != 1) begin
      errors++;
      $display("FAIL midframe_restart: got flat=%h wr=%0d, need 00005a00 1", bus.o_Reg_Flat, n_wr - w0);
    end
  endtask

  initial begin
    test_reset();
    test_valid();
    test_bad_chk();
    test_bad_addr();
    test_timeout();
    test_junk();
    test_back_to_back();
    test_random();
    test_saturate();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
